// File: rtl/startup_seq_pkg.sv
// Shared types and widths for the startup reset sequencer.
package startup_seq_pkg;
  localparam int STATE_W = 3;
  localparam int CNT_W   = 16;
  localparam int IDX_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_EOS = 3'd0,
    DELAY    = 3'd1,
    RELEASE  = 3'd2,
    RUN      = 3'd3,
    DRAIN    = 3'd4,
    ACK      = 3'd5
  } state_e;
endpackage

// File: rtl/startup_reset_sequencer_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level input.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/startup_reset_sequencer.sv
// Staggered release/assert of downstream channel resets around End-Of-Startup,
// with a PROGRAM request drain-and-acknowledge handshake.
module startup_reset_sequencer
  import startup_seq_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EOS_DELAY   = 16,
  parameter int STAGGER     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               eos_i,
  input  logic               preq_i,
  output logic [N_CH-1:0]    ch_rst_n_o,
  output logic               ready_o,
  output logic               pack_o,
  output logic [STATE_W-1:0] state_o
);
  localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(EOS_DELAY - 1);
  localparam logic [CNT_W-1:0] STG_LD = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_CH - 1);

  logic eos_s, preq_s, preq_q, preq_rise;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_CH-1:0]  ch_d;
  logic             ready_d, pack_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_eos  (.clk(clk), .rst_n(rst_n), .d(eos_i),  .q(eos_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_preq (.clk(clk), .rst_n(rst_n), .d(preq_i), .q(preq_s));

  assign preq_rise = preq_s & ~preq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_EOS;
      cnt_q      <= '0;
      idx_q      <= '0;
      preq_q     <= 1'b0;
      ch_rst_n_o <= '0;
      ready_o    <= 1'b0;
      pack_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      preq_q     <= preq_s;
      ch_rst_n_o <= ch_d;
      ready_o    <= ready_d;
      pack_o     <= pack_d;
    end
  end

  // idx always names the highest channel currently released (or last asserted in DRAIN).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ch_d    = ch_rst_n_o;
    case (state_q)
      WAIT_EOS: begin
        ch_d = '0;
        if (preq_rise) state_d = ACK;
        else if (eos_s) begin
          state_d = DELAY;
          cnt_d   = DLY_LD;
        end
      end
      DELAY: begin
        if (!eos_s) begin
          state_d = WAIT_EOS;
          ch_d    = '0;
        end else if (preq_rise) state_d = ACK;
        else if (cnt_q == '0) begin
          state_d = RELEASE;
          ch_d    = N_CH'(1);
          idx_d   = '0;
          cnt_d   = STG_LD;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      RELEASE: begin
        if (!eos_s) begin
          state_d = WAIT_EOS;
          ch_d    = '0;
        end else if (preq_rise) begin
          state_d = DRAIN;
          ch_d    = ch_rst_n_o & ~(N_CH'(1) << idx_q);
          cnt_d   = STG_LD;
        end else if (idx_q == LAST) state_d = RUN;
        else if (cnt_q == '0) begin
          ch_d  = ch_rst_n_o | (N_CH'(1) << (idx_q + IDX_W'(1)));
          idx_d = idx_q + IDX_W'(1);
          cnt_d = STG_LD;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      RUN: begin
        if (!eos_s) begin
          state_d = WAIT_EOS;
          ch_d    = '0;
        end else if (preq_rise) begin
          state_d = DRAIN;
          ch_d    = ch_rst_n_o & ~(N_CH'(1) << idx_q);
          cnt_d   = STG_LD;
        end
      end
      DRAIN: begin
        if (!eos_s) begin
          state_d = WAIT_EOS;
          ch_d    = '0;
        end else if (idx_q == '0) state_d = ACK;
        else if (cnt_q == '0) begin
          ch_d  = ch_rst_n_o & ~(N_CH'(1) << (idx_q - IDX_W'(1)));
          idx_d = idx_q - IDX_W'(1);
          cnt_d = STG_LD;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ACK: begin
        ch_d = '0;
        if (!preq_s) state_d = WAIT_EOS;
      end
      default: begin
        state_d = WAIT_EOS;
        ch_d    = '0;
      end
    endcase
  end

  // Flags are decoded from the next state so the registered outputs track state_o.
  always_comb begin
    ready_d = (state_d == RUN);
    pack_d  = (state_d == ACK);
  end

  assign state_o = state_q;
endmodule

// File: tb/tb_startup_reset_sequencer.sv
// Directed bench: timestamp-based behavioural model checked every cycle on two
// configurations, plus literal timing expectations.
module tb_startup_reset_sequencer;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic eos_i = 1'b0;
  logic preq_i = 1'b0;
  logic [3:0] ch_a;
  logic       rdy_a, pack_a;
  logic [2:0] st_a;
  logic [0:0] ch_b;
  logic       rdy_b, pack_b;
  logic [2:0] st_b;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  startup_reset_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .eos_i(eos_i), .preq_i(preq_i),
    .ch_rst_n_o(ch_a), .ready_o(rdy_a), .pack_o(pack_a), .state_o(st_a));

  startup_reset_sequencer #(.N_CH(1), .SYNC_STAGES(SYNC), .EOS_DELAY(1), .STAGGER(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .eos_i(eos_i), .preq_i(preq_i),
    .ch_rst_n_o(ch_b), .ready_o(rdy_b), .pack_o(pack_b), .state_o(st_b));

  // Model: phase (0 idle, 1 counting, 2 releasing, 3 running, 4 draining, 5 ack),
  // t = edge the phase was entered, h0 = highest channel asserted at drain entry.
  typedef struct packed { int ph; int t; int h0; int cyc; } mst_t;

  function automatic mst_t mstep(mst_t s, bit es, bit ps, bit pprev, int n, int stg, int dly);
    mst_t r;
    int c, live;
    bit pr;
    r = s;
    c = s.cyc + 1;
    r.cyc = c;
    pr = ps & ~pprev;
    case (s.ph)
      0: if (pr) r.ph = 5;
         else if (es) begin r.ph = 1; r.t = c; end
      1: if (!es) r.ph = 0;
         else if (pr) r.ph = 5;
         else if (c - s.t == dly) begin r.ph = 2; r.t = c; end
      2: begin
        live = 1 + (c - 1 - s.t) / stg;
        if (live > n) live = n;
        if (!es) r.ph = 0;
        else if (pr) begin r.ph = 4; r.h0 = live - 1; r.t = c; end
        else if (c - s.t == (n - 1) * stg + 1) r.ph = 3;
      end
      3: if (!es) r.ph = 0;
         else if (pr) begin r.ph = 4; r.h0 = n - 1; r.t = c; end
      4: if (!es) r.ph = 0;
         else if (c - s.t == s.h0 * stg + 1) r.ph = 5;
      default: if (!ps) r.ph = 0;
    endcase
    return r;
  endfunction

  function automatic int mmask(mst_t s, int n, int stg);
    int k;
    case (s.ph)
      2: begin k = 1 + (s.cyc - s.t) / stg; if (k > n) k = n; return (1 << k) - 1; end
      3: return (1 << n) - 1;
      4: begin k = s.h0 - (s.cyc - s.t) / stg; if (k < 0) k = 0; return (1 << k) - 1; end
      default: return 0;
    endcase
  endfunction

  mst_t ma = '0;
  mst_t mb = '0;
  logic [7:0] eh = '0;
  logic [7:0] ph = '0;

  // eh[j]/ph[j] hold the raw input sampled j+1 edges ago.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
      eh <= '0;
      ph <= '0;
    end else begin
      ma <= mstep(ma, eh[SYNC-1], ph[SYNC-1], ph[SYNC], 4, 8, 16);
      mb <= mstep(mb, eh[SYNC-1], ph[SYNC-1], ph[SYNC], 1, 1, 1);
      eh <= {eh[6:0], eos_i};
      ph <= {ph[6:0], preq_i};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_a_ch",    {28'd0, ch_a},  mmask(ma, 4, 8));
      chk("m_a_ready", {31'd0, rdy_a}, (ma.ph == 3) ? 1 : 0);
      chk("m_a_pack",  {31'd0, pack_a}, (ma.ph == 5) ? 1 : 0);
      chk("m_a_state", {29'd0, st_a},  ma.ph);
      chk("m_b_ch",    {31'd0, ch_b},  mmask(mb, 1, 1));
      chk("m_b_ready", {31'd0, rdy_b}, (mb.ph == 3) ? 1 : 0);
      chk("m_b_pack",  {31'd0, pack_b}, (mb.ph == 5) ? 1 : 0);
      chk("m_b_state", {29'd0, st_b},  mb.ph);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    chk("rst_ch_a", {28'd0, ch_a}, 0);
    chk("rst_ready_a", {31'd0, rdy_a}, 0);
    chk("rst_pack_a", {31'd0, pack_a}, 0);
    chk("rst_state_a", {29'd0, st_a}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step(2);

    // Power-up release, both configurations (cycle 0 = now).
    eos_i = 1'b1;
    step(4);  chk("b_ch0_c4", {31'd0, ch_b}, 1); chk("b_rdy_c4", {31'd0, rdy_b}, 0);
    step(1);  chk("b_rdy_c5", {31'd0, rdy_b}, 1); chk("b_st_c5", {29'd0, st_b}, 3);
    step(13); chk("a_ch_c18", {28'd0, ch_a}, 4'b0000);
    step(1);  chk("a_ch_c19", {28'd0, ch_a}, 4'b0001);
    step(8);  chk("a_ch_c27", {28'd0, ch_a}, 4'b0011);
    step(8);  chk("a_ch_c35", {28'd0, ch_a}, 4'b0111);
    step(8);  chk("a_ch_c43", {28'd0, ch_a}, 4'b1111); chk("a_rdy_c43", {31'd0, rdy_a}, 0);
    step(1);  chk("a_rdy_c44", {31'd0, rdy_a}, 1); chk("a_st_c44", {29'd0, st_a}, 3);

    // PROGRAM request from RUN.
    preq_i = 1'b1;
    step(2);  chk("a_rdy_p2", {31'd0, rdy_a}, 1);
    step(1);  chk("a_rdy_p3", {31'd0, rdy_a}, 0); chk("a_ch_p3", {28'd0, ch_a}, 4'b0111);
              chk("b_ch_p3", {31'd0, ch_b}, 0);
    step(8);  chk("a_ch_p11", {28'd0, ch_a}, 4'b0011); chk("b_pack_p11", {31'd0, pack_b}, 1);
    step(8);  chk("a_ch_p19", {28'd0, ch_a}, 4'b0001);
    step(8);  chk("a_ch_p27", {28'd0, ch_a}, 4'b0000); chk("a_pack_p27", {31'd0, pack_a}, 0);
    step(1);  chk("a_pack_p28", {31'd0, pack_a}, 1); chk("a_st_p28", {29'd0, st_a}, 5);
    preq_i = 1'b0;
    step(2);  chk("a_pack_q2", {31'd0, pack_a}, 1);
    step(1);  chk("a_pack_q3", {31'd0, pack_a}, 0); chk("a_st_q3", {29'd0, st_a}, 0);
    eos_i = 1'b0;
    step(5);

    // EOS loss while two channels are released.
    eos_i = 1'b1;
    step(27); chk("a_ch_e27", {28'd0, ch_a}, 4'b0011);
    eos_i = 1'b0;
    step(2);  chk("a_ch_e29", {28'd0, ch_a}, 4'b0011);
    step(1);  chk("a_ch_e30", {28'd0, ch_a}, 4'b0000); chk("a_st_e30", {29'd0, st_a}, 0);
              chk("a_pack_e30", {31'd0, pack_a}, 0);
    step(3);  chk("a_pack_e33", {31'd0, pack_a}, 0);

    // PROGRAM request during the EOS delay.
    eos_i = 1'b1;
    step(5);
    preq_i = 1'b1;
    step(3);  chk("a_st_d8", {29'd0, st_a}, 5); chk("a_pack_d8", {31'd0, pack_a}, 1);
              chk("a_ch_d8", {28'd0, ch_a}, 0);
    step(20);
    preq_i = 1'b0;
    step(3);  chk("a_st_d31", {29'd0, st_a}, 0);
    eos_i = 1'b0;
    step(5);

    // PROGRAM request after two channels are released.
    eos_i = 1'b1;
    step(28); chk("a_ch_r28", {28'd0, ch_a}, 4'b0011);
    preq_i = 1'b1;
    step(3);  chk("a_ch_r31", {28'd0, ch_a}, 4'b0001); chk("a_st_r31", {29'd0, st_a}, 4);
    step(8);  chk("a_ch_r39", {28'd0, ch_a}, 4'b0000); chk("a_pack_r39", {31'd0, pack_a}, 0);
    step(1);  chk("a_pack_r40", {31'd0, pack_a}, 1);
    preq_i = 1'b0;
    step(3);  chk("a_st_r43", {29'd0, st_a}, 0);
    eos_i = 1'b0;
    step(5);

    // Reset pulse mid-release, then full re-release.
    eos_i = 1'b1;
    step(30); chk("a_ch_x30", {28'd0, ch_a}, 4'b0011);
    #2 rst_n = 1'b0;
    #1;
    chk("a_ch_xrst", {28'd0, ch_a}, 0); chk("a_rdy_xrst", {31'd0, rdy_a}, 0);
    chk("a_pack_xrst", {31'd0, pack_a}, 0); chk("a_st_xrst", {29'd0, st_a}, 0);
    chk("b_ch_xrst", {31'd0, ch_b}, 0);
    #2 rst_n = 1'b1;
    step(18); chk("a_ch_y18", {28'd0, ch_a}, 4'b0000);
    step(1);  chk("a_ch_y19", {28'd0, ch_a}, 4'b0001);
    step(8);  chk("a_ch_y27", {28'd0, ch_a}, 4'b0011);
    step(16); chk("a_ch_y43", {28'd0, ch_a}, 4'b1111);
    step(1);  chk("a_rdy_y44", {31'd0, rdy_a}, 1);

    // PROGRAM request while idle goes straight to acknowledge.
    eos_i = 1'b0;
    step(6);  chk("a_st_w6", {29'd0, st_a}, 0); chk("a_rdy_w6", {31'd0, rdy_a}, 0);
    preq_i = 1'b1;
    step(3);  chk("a_st_w9", {29'd0, st_a}, 5); chk("a_pack_w9", {31'd0, pack_a}, 1);
    preq_i = 1'b0;
    step(3);  chk("a_st_w12", {29'd0, st_a}, 0);
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
